// File: rtl/ysyx_220053_clint.sv
// Core-local interruptor for the single-hart NPC: mtime/mtimecmp/msip on a
// valid/ready slave port, plus the commit-qualified timer-interrupt take pulse.
module ysyx_220053_clint #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        mstatus_MIE,
  input  logic        mie_MITE,
  input  logic        commit_valid,
  output logic        time_irq,
  output logic        mtip,
  output logic        msip_o
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
  localparam logic [15:0] DIV_LAST     = 16'(TICK_DIV - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] presc;
  logic        take_q;

  logic        tick;
  logic        accept;
  logic [15:0] offset;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic        mapped;
  logic [63:0] rd_data;
  logic        wr_msip;
  logic        wr_cmp;
  logic        wr_time;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  // Handshake: a request transfers on an edge where req_valid & req_ready;
  // the response appears one edge later and is held, unchanged, until an edge
  // where resp_valid & resp_ready. Only one transaction is ever outstanding,
  // so a new request is accepted exactly when the slot is free or draining.
  assign req_ready = ~resp_valid | resp_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    offset   = req_addr & BASE_MASK;
    hit_msip = (offset == OFF_MSIP);
    hit_cmp  = (offset == OFF_MTIMECMP);
    hit_time = (offset == OFF_MTIME);
    mapped   = hit_msip | hit_cmp | hit_time;
    rd_data  = '0;
    if (hit_msip) rd_data = {63'b0, msip};
    if (hit_cmp)  rd_data = mtimecmp;
    if (hit_time) rd_data = mtime;
    wr_msip  = accept & req_we & hit_msip;
    wr_cmp   = accept & req_we & hit_cmp;
    wr_time  = accept & req_we & hit_time;
  end

  assign tick = (presc == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A bus write to mtime takes priority over the tick; the prescaler keeps running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_time) begin
      mtime <= merge_bytes(mtime, req_wdata, req_wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtimecmp <= '1;
    end else if (wr_cmp) begin
      mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msip <= 1'b0;
    end else if (wr_msip && req_wmask[0]) begin
      msip <= req_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= ~mapped;
      resp_rdata <= req_we ? 64'd0 : rd_data;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // take_q blocks a second pulse while the CSR unit is still clearing MIE.
  assign time_irq = mtip & mstatus_MIE & mie_MITE & commit_valid & ~take_q;
  assign msip_o   = msip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtip   <= 1'b0;
      take_q <= 1'b0;
    end else begin
      mtip   <= (mtime >= mtimecmp);
      take_q <= time_irq;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_clint.sv
// Directed bench for ysyx_220053_clint: bus responses are scoreboarded through
// an expected queue, interrupt levels/pulses are checked cycle by cycle.
module tb_ysyx_220053_clint;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mstatus_MIE = 1'b0;
  logic        mie_MITE = 1'b0;
  logic        commit_valid = 1'b0;
  logic        time_irq;
  logic        mtip;
  logic        msip_o;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT  = 64'h0123_4567_89AB_CDEF;

  // clock / reset
  always #5 clk = ~clk;

  ysyx_220053_clint #(.TICK_DIV(4), .BASE_MASK(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mstatus_MIE(mstatus_MIE), .mie_MITE(mie_MITE), .commit_valid(commit_valid),
    .time_irq(time_irq), .mtip(mtip), .msip_o(msip_o)
  );

  // scoreboard: {err, lo, hi}; rdata must lie in [lo, hi]
  logic [128:0] exp_q[$];
  logic [128:0] exp_e;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got rdata %h err %b with no response expected",
                 resp_rdata, resp_err);
      end else begin
        exp_e = exp_q.pop_front();
        if ($isunknown({resp_err, resp_rdata}) || resp_err !== exp_e[128] ||
            resp_rdata < exp_e[127:64] || resp_rdata > exp_e[63:0]) begin
          miscompares++;
          $display("FAIL bus_resp: got rdata %h err %b expected rdata %h..%h err %b",
                   resp_rdata, resp_err, exp_e[127:64], exp_e[63:0], exp_e[128]);
        end
      end
    end
  end

  // driver tasks: all inputs change 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input logic err,
                     input logic [63:0] lo, input logic [63:0] hi);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept_timeout: req_ready %b after %0d cycles, required 1", req_ready, n);
    end else begin
      exp_q.push_back({err, lo, hi});
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wmask = '0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] mask);
    bus(1'b1, addr, data, mask, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [63:0] exp);
    bus(1'b0, addr, 64'd0, 8'h00, 1'b0, exp, exp);
  endtask

  task automatic rd_range(input logic [15:0] addr, input logic [63:0] lo, input logic [63:0] hi);
    bus(1'b0, addr, 64'd0, 8'h00, 1'b0, lo, hi);
  endtask

  initial begin
    int n;
    // reset state
    idle(3);
    check("rst_mtip", mtip, 0);
    check("rst_time_irq", time_irq, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_msip_o", msip_o, 0);
    check("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;

    // reset values over the bus
    rd_range(16'hBFF8, 64'd0, 64'd10);
    rd(16'h4000, ONES);
    rd(16'h0000, 64'd0);

    // prescaler: 40 cycles at TICK_DIV=4 gives 10 ticks
    wr(16'hBFF8, 64'd0, 8'hFF);
    idle(40);
    rd_range(16'hBFF8, 64'd9, 64'd11);

    // byte-masked writes
    wr(16'hBFF8, 64'h1234, 8'hFF);
    wr(16'hBFF8, 64'h55, 8'h01);
    rd_range(16'hBFF8, 64'h1255, 64'h1257);
    wr(16'h4000, 64'h1234, 8'hFF);
    wr(16'h4000, 64'h55, 8'h01);
    wr(16'h4000, 64'hAB00, 8'h02);
    rd(16'h4000, 64'hAB55);
    wr(16'h4000, ONES, 8'hFF);
    wr(16'h4000, 64'h7700_0000_0000_0000, 8'h80);
    rd(16'h4000, 64'h77FF_FFFF_FFFF_FFFF);
    wr(16'h4000, ONES, 8'hFF);

    // msip: bit 0 only
    wr(16'h0000, 64'hFFFF_FFFF, 8'h0F);
    rd(16'h0000, 64'd1);
    check("msip_o_set", msip_o, 1);
    wr(16'h0000, 64'd0, 8'h01);
    rd(16'h0000, 64'd0);
    check("msip_o_clr", msip_o, 0);

    // timer compare and take pulse with commit held high
    wr(16'h4000, ONES, 8'hFF);
    wr(16'hBFF8, 64'd0, 8'hFF);
    wr(16'h4000, 64'd20, 8'hFF);
    idle(2);
    check("mtip_below_cmp", mtip, 0);
    mstatus_MIE = 1'b1;
    mie_MITE = 1'b1;
    commit_valid = 1'b1;
    idle(1);
    wr(16'hBFF8, 64'd20, 8'hFF);
    check("mtip_same_edge", mtip, 0);
    check("irq_before_mtip", time_irq, 0);
    idle(1);
    check("mtip_rise", mtip, 1);
    check("irq_first", time_irq, 1);
    idle(1);
    check("irq_guard", time_irq, 0);
    mstatus_MIE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("irq_mie_off", time_irq, 0);
    end
    mstatus_MIE = 1'b1;
    #1;
    check("irq_mie_back", time_irq, 1);
    idle(1);
    check("irq_mie_back_guard", time_irq, 0);
    mstatus_MIE = 1'b0;
    commit_valid = 1'b0;

    // compare reached by counting
    wr(16'h4000, ONES, 8'hFF);
    wr(16'hBFF8, 64'd0, 8'hFF);
    wr(16'h4000, 64'd5, 8'hFF);
    n = 0;
    while (!mtip && n < 60) begin
      idle(1);
      n++;
    end
    check("mtip_natural_rise", mtip, 1);

    // mtimecmp all-ones drops mtip
    wr(16'h4000, ONES, 8'hFF);
    idle(1);
    check("mtip_cmp_ones", mtip, 0);

    // commit gating
    wr(16'hBFF8, 64'd0, 8'hFF);
    wr(16'h4000, 64'd20, 8'hFF);
    mstatus_MIE = 1'b1;
    mie_MITE = 1'b1;
    wr(16'hBFF8, 64'd20, 8'hFF);
    idle(1);
    check("mtip_rise_nocommit", mtip, 1);
    check("irq_nocommit", time_irq, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("irq_nocommit", time_irq, 0);
    end
    commit_valid = 1'b1;
    #1;
    check("irq_on_commit", time_irq, 1);
    idle(1);
    check("irq_commit_guard", time_irq, 0);
    mstatus_MIE = 1'b0;
    commit_valid = 1'b0;
    wr(16'h4000, ONES, 8'hFF);

    // stalled response
    wr(16'h4000, PAT, 8'hFF);
    idle(2);
    resp_ready = 1'b0;
    rd(16'h4000, PAT);
    for (int i = 0; i < 3; i++) begin
      check("stall_req_ready", req_ready, 0);
      check("stall_resp_valid", resp_valid, 1);
      check("stall_rdata", resp_rdata, PAT);
      idle(1);
    end
    resp_ready = 1'b1;
    #1;
    check("stall_release_ready", req_ready, 1);
    rd(16'h0000, 64'd0);

    // unmapped offset
    bus(1'b0, 16'h1000, 64'd0, 8'h00, 1'b1, 64'd0, 64'd0);
    wr(16'h0000, 64'd1, 8'h01);
    wr(16'h4000, 64'hCAFE, 8'hFF);
    bus(1'b1, 16'h1000, ONES, 8'hFF, 1'b1, 64'd0, 64'd0);
    rd(16'h0000, 64'd1);
    rd(16'h4000, 64'hCAFE);
    rd_range(16'hBFF8, 64'd0, 64'd500);

    // reset drops an in-flight response
    idle(2);
    resp_ready = 1'b0;
    rd(16'h4000, 64'hCAFE);
    void'(exp_q.pop_back());
    check("inflight_valid", resp_valid, 1);
    rst_n = 1'b0;
    idle(1);
    check("rst_drop_valid", resp_valid, 0);
    check("rst_drop_err", resp_err, 0);
    check("rst_drop_rdata", resp_rdata, 64'd0);
    check("rst_drop_mtip", mtip, 0);
    check("rst_drop_msip", msip_o, 0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    rd(16'h4000, ONES);
    rd(16'h0000, 64'd0);

    // drain and report
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
